// File: rtl/keysched_pkg.sv
// Shared types for the RC4 key-search scheduler: FSM state encoding,
// default key width and the key typedef.
package keysched_pkg;

  localparam int unsigned KEY_W_DEFAULT = 24;

  typedef logic [KEY_W_DEFAULT-1:0] key_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FOUND,
    ST_EXHAUSTED,
    ST_TIMEOUT
  } keysched_state_t;

endpackage

// File: rtl/keysched_slot.sv
// One dispatch slot of the key-search scheduler: busy flag, key register,
// start-pulse register and, when KEYSCHED_WATCHDOG_EN is defined, a
// per-attempt cycle counter that raises expire when the budget runs out.
module keysched_slot #(
  parameter int unsigned KEY_W           = 24,
  parameter int unsigned WATCHDOG_CYCLES = 65536
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [KEY_W-1:0] load_key,
  input  logic             done,
  output logic             busy,
  output logic             start,
  output logic [KEY_W-1:0] key,
  output logic             expire
);

  // Slot ownership, key hold and start pulse; a load wins over clear/done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy  <= 1'b0;
      start <= 1'b0;
      key   <= '0;
    end else begin
      start <= load;
      if (load) begin
        busy <= 1'b1;
        key  <= load_key;
      end else if (clear || done) begin
        busy <= 1'b0;
      end
    end
  end

`ifdef KEYSCHED_WATCHDOG_EN
  localparam int unsigned CW = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;

  logic [CW-1:0] wd_cnt;

  // Counts busy cycles since the start pulse; saturates at the last budget cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (load || clear) begin
      wd_cnt <= '0;
    end else if (busy && (wd_cnt != CW'(WATCHDOG_CYCLES - 1))) begin
      wd_cnt <= wd_cnt + CW'(1);
    end
  end

  // The budget's final cycle expires unless the core answers in that same cycle.
  assign expire = busy && (wd_cnt == CW'(WATCHDOG_CYCLES - 1)) && !done;
`else
  logic unused_wd;
  assign unused_wd = ^WATCHDOG_CYCLES;
  assign expire    = 1'b0;
`endif

endmodule

// File: rtl/key_search_scheduler.sv
// Brute-force RC4 key-search scheduler. Issues keys 0..KEY_LIMIT in order to
// NUM_CORES decrypt cores, latches the first winning key and broadcasts stop,
// or reports exhaustion. Optional per-attempt watchdog: KEYSCHED_WATCHDOG_EN.
module key_search_scheduler
  import keysched_pkg::*;
#(
  parameter int unsigned      NUM_CORES       = 4,
  parameter int unsigned      KEY_W           = KEY_W_DEFAULT,
  parameter logic [KEY_W-1:0] KEY_LIMIT       = 24'h3FFFFF,
  parameter int unsigned      WATCHDOG_CYCLES = 65536
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       go,
  output logic [NUM_CORES-1:0]       core_start,
  output logic [NUM_CORES*KEY_W-1:0] core_key,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES-1:0]       core_success,
  output logic                       stop,
  output logic                       busy,
  output logic                       found,
  output logic                       exhausted,
  output logic                       timeout,
  output logic [KEY_W-1:0]           found_key
);

  keysched_state_t state_q, state_d;

  logic [KEY_W:0]         next_key_q, next_key_d;
  logic [NUM_CORES-1:0]   slot_busy, slot_start, slot_expire, slot_load, slot_done;
  logic [NUM_CORES-1:0]   win_vec, free_sel;
  logic [KEY_W-1:0]       slot_key [NUM_CORES];
  logic [KEY_W-1:0]       load_key, win_key, found_key_d;
  logic                   slot_clear, win_hit, free_hit, keys_left, restart;
  logic                   busy_d, stop_d, found_d, exhausted_d, timeout_d;

  assign keys_left = next_key_q <= {1'b0, KEY_LIMIT};
  assign restart   = go && (state_q != ST_RUN);
  // Completions only matter while searching; late pulses after stop are dropped.
  assign slot_done = (state_q == ST_RUN) ? core_done : '0;
  assign win_vec   = slot_done & core_success & slot_busy;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
    keysched_slot #(
      .KEY_W           (KEY_W),
      .WATCHDOG_CYCLES (WATCHDOG_CYCLES)
    ) u_slot (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (slot_clear),
      .load     (slot_load[g]),
      .load_key (load_key),
      .done     (slot_done[g]),
      .busy     (slot_busy[g]),
      .start    (slot_start[g]),
      .key      (slot_key[g]),
      .expire   (slot_expire[g])
    );
    assign core_key[g*KEY_W +: KEY_W] = slot_key[g];
  end

  assign core_start = slot_start;

  // Priority encoders: lowest-index winner and lowest-index free slot.
  always_comb begin
    win_hit  = 1'b0;
    win_key  = '0;
    free_hit = 1'b0;
    free_sel = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!win_hit && win_vec[i]) begin
        win_hit = 1'b1;
        win_key = slot_key[i];
      end
      if (!free_hit && !slot_busy[i]) begin
        free_hit    = 1'b1;
        free_sel[i] = 1'b1;
      end
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      next_key_q <= '0;
      busy       <= 1'b0;
      stop       <= 1'b0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
      timeout    <= 1'b0;
      found_key  <= '0;
    end else begin
      state_q    <= state_d;
      next_key_q <= next_key_d;
      busy       <= busy_d;
      stop       <= stop_d;
      found      <= found_d;
      exhausted  <= exhausted_d;
      timeout    <= timeout_d;
      found_key  <= found_key_d;
    end
  end

  // Next-state: success beats watchdog, which beats exhaustion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (win_hit)                                 state_d = ST_FOUND;
        else if (|slot_expire)                       state_d = ST_TIMEOUT;
        else if (!keys_left && (slot_busy == '0))    state_d = ST_EXHAUSTED;
      end
      default: begin
        if (go) state_d = ST_RUN;
      end
    endcase
  end

  // Dispatch, key counter and result latch; a restart issues key 0 to slot 0
  // in the same cycle it clears everything else.
  always_comb begin
    slot_clear  = restart;
    slot_load   = '0;
    load_key    = next_key_q[KEY_W-1:0];
    next_key_d  = next_key_q;
    found_key_d = found_key;
    if (restart) begin
      slot_load   = NUM_CORES'(1);
      load_key    = '0;
      next_key_d  = (KEY_W+1)'(1);
      found_key_d = '0;
    end else if (state_q == ST_RUN) begin
      if ((state_d == ST_RUN) && keys_left && free_hit) begin
        slot_load  = free_sel;
        next_key_d = next_key_q + (KEY_W+1)'(1);
      end
      if (win_hit) found_key_d = win_key;
    end
    busy_d      = (state_d == ST_RUN);
    stop_d      = (state_d == ST_FOUND) || (state_d == ST_TIMEOUT);
    found_d     = (state_d == ST_FOUND);
    exhausted_d = (state_d == ST_EXHAUSTED);
    timeout_d   = (state_d == ST_TIMEOUT);
  end

endmodule
